// File: rtl/multicycle_control.sv
// Main sequencer for the multi-cycle SAMAB CPU datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback and drives
// the datapath enables plus the ops code for ALU control. A single shared memory is
// accessed through a req/ready handshake; FETCH, MEM_RD and MEM_WR wait on mem_ready.
module multicycle_control #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned OPSW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [OPSW-1:0] ops,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            ir_write,
  output logic            mem_req,
  output logic            mem_we,
  output logic            iord,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            halted,
  output logic            illegal
);

  // Instruction opcodes
  localparam logic [OPW-1:0] OpRType = OPW'(0);
  localparam logic [OPW-1:0] OpAddi  = OPW'(1);
  localparam logic [OPW-1:0] OpLw    = OPW'(2);
  localparam logic [OPW-1:0] OpSw    = OPW'(3);
  localparam logic [OPW-1:0] OpBeq   = OPW'(4);
  localparam logic [OPW-1:0] OpJmp   = OPW'(5);
  localparam logic [OPW-1:0] OpHalt  = OPW'(15);

  // ALU control codes
  localparam logic [OPSW-1:0] OpsIdle = OPSW'(0);
  localparam logic [OPSW-1:0] OpsR    = OPSW'(1);
  localparam logic [OPSW-1:0] OpsAdd  = OPSW'(2);
  localparam logic [OPSW-1:0] OpsSub  = OPSW'(4);

  typedef enum logic [3:0] {
    StRst,
    StFetch,
    StDecode,
    StExecR,
    StWbR,
    StExecI,
    StWbI,
    StAddr,
    StMemRd,
    StMemWr,
    StWbMem,
    StBranch,
    StJump,
    StHalt
  } state_t;

  // State-only (Moore) part of the outputs
  typedef struct packed {
    logic [OPSW-1:0] ops;
    logic            jump_load;
    logic [1:0]      pc_src;
    logic            mem_req;
    logic            mem_we;
    logic            iord;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic            reg_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            halted;
  } moore_t;

  state_t state_q, state_d;
  moore_t moore_q;

  // Output pattern for each state; anything not set is 0
  function automatic moore_t moore_of(state_t s);
    moore_t m;
    m = '0;
    case (s)
      StFetch: begin
        m.mem_req   = 1'b1;
        m.alu_src_b = 2'd1;
        m.ops       = OpsAdd;
      end
      StDecode: begin
        m.alu_src_b = 2'd2;
        m.ops       = OpsAdd;
      end
      StExecR: begin
        m.alu_src_a = 1'b1;
        m.alu_src_b = 2'd0;
        m.ops       = OpsR;
      end
      StWbR: begin
        m.reg_write = 1'b1;
        m.reg_dst   = 1'b1;
      end
      StExecI, StAddr: begin
        m.alu_src_a = 1'b1;
        m.alu_src_b = 2'd2;
        m.ops       = OpsAdd;
      end
      StWbI: begin
        m.reg_write = 1'b1;
      end
      StMemRd: begin
        m.mem_req = 1'b1;
        m.iord    = 1'b1;
      end
      StMemWr: begin
        m.mem_req = 1'b1;
        m.iord    = 1'b1;
        m.mem_we  = 1'b1;
      end
      StWbMem: begin
        m.reg_write  = 1'b1;
        m.mem_to_reg = 1'b1;
      end
      StBranch: begin
        m.alu_src_a = 1'b1;
        m.alu_src_b = 2'd0;
        m.ops       = OpsSub;
        m.pc_src    = 2'd1;
      end
      StJump: begin
        m.jump_load = 1'b1;
        m.pc_src    = 2'd2;
      end
      StHalt: begin
        m.halted = 1'b1;
      end
      default: m.ops = OpsIdle;
    endcase
    return m;
  endfunction

  // Opcodes that have a defined execution path
  function automatic logic is_legal(logic [OPW-1:0] op);
    return (op == OpRType) || (op == OpAddi) || (op == OpLw) || (op == OpSw) ||
           (op == OpBeq) || (op == OpJmp) || (op == OpHalt);
  endfunction

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRst:    state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpRType:     state_d = StExecR;
          OpAddi:      state_d = StExecI;
          OpLw, OpSw:  state_d = StAddr;
          OpBeq:       state_d = StBranch;
          OpJmp:       state_d = StJump;
          OpHalt:      state_d = StHalt;
          default:     state_d = StFetch;
        endcase
      end
      StExecR:  state_d = StWbR;
      StWbR:    state_d = StFetch;
      StExecI:  state_d = StWbI;
      StWbI:    state_d = StFetch;
      StAddr: begin
        if (opcode == OpLw)      state_d = StMemRd;
        else if (opcode == OpSw) state_d = StMemWr;
        else                     state_d = StFetch;
      end
      StMemRd:  if (mem_ready) state_d = StWbMem;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StWbMem:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StRst;
    endcase
  end

  // State register; outputs are registered as the decode of the next state so they
  // always match the state held, and async reset clears both at once (drops mem_req).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRst;
      moore_q <= '0;
    end else begin
      state_q <= state_d;
      moore_q <= moore_of(state_d);
    end
  end

  logic in_fetch, in_branch, in_decode;

  // Mealy exceptions: fetch completion, branch taken, illegal opcode in decode
  always_comb begin
    in_fetch   = (state_q == StFetch);
    in_branch  = (state_q == StBranch);
    in_decode  = (state_q == StDecode);
    ops        = moore_q.ops;
    pc_src     = moore_q.pc_src;
    mem_req    = moore_q.mem_req;
    mem_we     = moore_q.mem_we;
    iord       = moore_q.iord;
    alu_src_a  = moore_q.alu_src_a;
    alu_src_b  = moore_q.alu_src_b;
    reg_write  = moore_q.reg_write;
    reg_dst    = moore_q.reg_dst;
    mem_to_reg = moore_q.mem_to_reg;
    halted     = moore_q.halted;
    ir_write   = in_fetch & mem_ready;
    pc_write   = moore_q.jump_load | (in_fetch & mem_ready) | (in_branch & zero);
    illegal    = in_decode & ~is_legal(opcode);
  end

endmodule
